// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, FSM states and
// a small helper that classifies arithmetic ops.
package alu_serial_pkg;

  // Op encoding shared by the 1-bit slice and the serial wrapper.
  // Codes 0 and 1 are illegal and produce an all-zero result.
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  // Sequencer states: waiting for operands, shifting bits, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Only ADD and SUB use the carry chain, so only they report carry/overflow.
  function automatic logic isArith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_serial_alu1.sv
// Single-bit ALU slice. Purely combinational; the serial wrapper owns the
// carry register and feeds one operand bit pair per cycle.
module alu1
  import alu_serial_pkg::*;
(
  output logic       out,
  output logic       carryout,
  input  logic       A,
  input  logic       B,
  input  logic       carryin,
  input  logic [2:0] control
);

  logic bEff;

  // Full adder for ADD/SUB (SUB inverts B, the caller seeds carry=1),
  // plain bitwise logic otherwise; illegal ops yield zero with no carry.
  always_comb begin
    bEff     = (control == ALU_SUB) ? ~B : B;
    out      = 1'b0;
    carryout = 1'b0;
    case (control)
      ALU_ADD, ALU_SUB: begin
        out      = A ^ bEff ^ carryin;
        carryout = (A & bEff) | (carryin & (A ^ bEff));
      end
      ALU_AND: out = A & B;
      ALU_OR:  out = A | B;
      ALU_NOR: out = ~(A | B);
      ALU_XOR: out = A ^ B;
      default: begin
        out      = 1'b0;
        carryout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU. Operands are accepted over a valid/ready
// handshake, processed LSB first through one alu1 slice with a registered
// carry, and the result plus flags are offered over a second handshake.
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opB_q;
  logic [2:0]       ctrl_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             carryFlag_q, overflowFlag_q, zeroFlag_q, negFlag_q;

  logic             accept;
  logic             lastBit;
  logic             sliceOut, sliceCarry;
  logic [WIDTH-1:0] resultNext;

  // The one and only bit slice; it sees the current bit pair and carry.
  alu1 u_slice (
    .out      (sliceOut),
    .carryout (sliceCarry),
    .A        (opA_q[idx_q]),
    .B        (opB_q[idx_q]),
    .carryin  (carry_q),
    .control  (ctrl_q)
  );

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; accept and finish strobes fall out here too.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    lastBit   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          lastBit = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result with the current slice bit merged in, so flags see the final word.
  always_comb begin
    resultNext        = result_q;
    resultNext[idx_q] = sliceOut;
  end

  // Operand latch, bit index, carry chain and result shift-in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opA_q    <= '0;
      opB_q    <= '0;
      ctrl_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      opA_q   <= A;
      opB_q   <= B;
      ctrl_q  <= control;
      idx_q   <= '0;
      carry_q <= (control == ALU_SUB);
    end else if (state_q == RUN) begin
      result_q <= resultNext;
      carry_q  <= sliceCarry;
      idx_q    <= lastBit ? '0 : idx_q + IDX_ONE;
    end
  end

  // Flags are captured once, on the final bit; the carry register still
  // holds the carry into the MSB at that moment, which gives overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carryFlag_q    <= 1'b0;
      overflowFlag_q <= 1'b0;
      zeroFlag_q     <= 1'b0;
      negFlag_q      <= 1'b0;
    end else if (lastBit) begin
      if (isArith(ctrl_q)) begin
        carryFlag_q    <= sliceCarry;
        overflowFlag_q <= carry_q ^ sliceCarry;
      end else begin
        carryFlag_q    <= 1'b0;
        overflowFlag_q <= 1'b0;
      end
      zeroFlag_q <= (resultNext == '0);
      negFlag_q  <= resultNext[WIDTH-1];
    end
  end

  assign out      = result_q;
  assign carryout = carryFlag_q;
  assign overflow = overflowFlag_q;
  assign zero     = zeroFlag_q;
  assign negative = negFlag_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for the bit-serial ALU with a scoreboard of expected
// results computed from a word-level reference model.
module tb_alu_serial;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [2:0]       control = 3'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out;
  logic             carryout, overflow, zero, negative;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;

  alu_serial #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Watchdog so a wedged design still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Word-level reference: flags packed as {carryout, overflow, zero, negative}.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] op);
    exp_t         e;
    logic [WIDTH:0] wide;
    logic         c, v;
    c    = 1'b0;
    v    = 1'b0;
    wide = '0;
    case (op)
      3'd2: begin
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
      end
      3'd3: begin
        wide = {1'b0, a} + {1'b0, ~b} + 1;
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
      end
      3'd4: wide[WIDTH-1:0] = a & b;
      3'd5: wide[WIDTH-1:0] = a | b;
      3'd6: wide[WIDTH-1:0] = ~(a | b);
      3'd7: wide[WIDTH-1:0] = a ^ b;
      default: wide = '0;
    endcase
    e.res   = wide[WIDTH-1:0];
    e.flags = {c, v, (wide[WIDTH-1:0] == '0), wide[WIDTH-1]};
    return e;
  endfunction

  // One comparison point: counts and reports through an immediate assertion.
  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Offer one op in IDLE, record its expectation, and scramble inputs after accept.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [2:0] op);
    A        = a;
    B        = b;
    control  = op;
    in_valid = 1'b1;
    sb.push_back(model(a, b, op));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    A        = ~a;
    B        = a ^ b;
    control  = op ^ 3'd1;
  endtask

  // Wait (bounded) for out_valid and check the latency from the accept edge.
  task automatic waitResult(input string tag);
    int cycles;
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(WIDTH));
  endtask

  // Pop the oldest expectation and compare the presented result and flags.
  task automatic checkOutput(input string tag);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check({tag, "_out"}, 64'(out), 64'(cur.res));
      check({tag, "_flags"}, 64'({carryout, overflow, zero, negative}), 64'(cur.flags));
    end
  endtask

  // Hand the result back and confirm the return to IDLE with out retained.
  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel_hs"}, 64'({out_valid, in_ready}), 64'b01);
    check({tag, "_rel_out"}, 64'(out), 64'(cur.res));
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op);
    applyStimulus(a, b, op);
    waitResult(tag);
    checkOutput(tag);
    releaseResult(tag);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_hs", 64'({in_ready, out_valid}), 64'b10);
    check("rst_out", 64'(out), 64'd0);
    check("rst_flags", 64'({carryout, overflow, zero, negative}), 64'd0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rel_hs", 64'({in_ready, out_valid}), 64'b10);

    // Arithmetic directed cases
    runOp("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'd2);
    runOp("sub_eq", 32'd5, 32'd5, 3'd3);
    runOp("sub_neg", 32'd0, 32'd1, 3'd3);

    // Logic ops
    runOp("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4);
    runOp("or",  32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5);
    runOp("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6);
    runOp("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7);

    // Illegal op codes
    runOp("ill0", 32'h1234_5678, 32'h9ABC_DEF0, 3'd0);
    runOp("ill1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1);

    // Backpressure: hold DONE, offer a new op that must be ignored
    applyStimulus(32'h8000_0000, 32'h8000_0000, 3'd2);
    waitResult("bp");
    checkOutput("bp");
    A        = 32'd1;
    B        = 32'd1;
    control  = 3'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check("bp_hold_hs", 64'({out_valid, in_ready}), 64'b10);
      check("bp_hold_out", 64'({out, carryout, overflow, zero, negative}),
            64'({cur.res, cur.flags}));
    end
    in_valid = 1'b0;
    releaseResult("bp");
    @(posedge clock);
    #1;
    check("bp_no_accept", 64'({in_ready, out_valid}), 64'b10);

    // Reset in the middle of RUN at idx=10
    applyStimulus(32'hAAAA_5555, 32'h1357_9BDF, 3'd2);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    check("mid_rst_hs", 64'({in_ready, out_valid}), 64'b10);
    check("mid_rst_out", 64'({out, carryout, overflow, zero, negative}), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    begin
      logic sawValid;
      sawValid = 1'b0;
      repeat (WIDTH + 4) begin
        @(posedge clock);
        #1;
        if (out_valid) sawValid = 1'b1;
      end
      check("mid_rst_no_valid", 64'(sawValid), 64'd0);
    end
    runOp("add_after_rst", 32'd3, 32'd4, 3'd2);

    // A few random operations across all legal codes
    for (int i = 0; i < 4; i++) begin
      runOp("rand", $urandom, $urandom, 3'($urandom_range(2, 7)));
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
